// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the instruction
// fetch port and the data (load/store) port.
// - Each granted request is latched into the m* registers and driven to memory
//   with a req/ack handshake.
// - Read data comes back with a one-cycle ready pulse on the granted port.
// - Ties alternate between the ports, and an optional watchdog aborts accesses
//   that the memory never acknowledges.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic [DATA_W-1:0] ifRdata,
   output logic              ifReady,
   input  logic              dReq,
   input  logic              dWrite,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   input  logic [1:0]        dMode,
   output logic [DATA_W-1:0] dRdata,
   output logic              dReady,
   output logic              err,
   output logic              mReq,
   output logic              mWrite,
   output logic [ADDR_W-1:0] mAddr,
   output logic [DATA_W-1:0] mWdata,
   output logic [1:0]        mMode,
   input  logic [DATA_W-1:0] mRdata,
   input  logic              mAck,
   output logic              stall
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic       GRANT_IF  = 1'b0;
   localparam logic       GRANT_D   = 1'b1;
   localparam logic [1:0] MODE_WORD = 2'b10;
   // The counter only has to reach TIMEOUT-1: the expiring cycle is the one
   // in which the count already equals TIMEOUT-1 and no ack arrives.
   localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic             WD_EN   = (TIMEOUT > 0);

   state_t            state, state_n;
   logic              grant, grant_n;
   logic              last_grant, last_grant_n;
   logic [CNT_W-1:0]  wd_cnt, wd_cnt_n;
   logic              m_req_n, m_write_n;
   logic [ADDR_W-1:0] m_addr_n;
   logic [DATA_W-1:0] m_wdata_n;
   logic [1:0]        m_mode_n;
   logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
   logic              if_ready_n, d_ready_n, err_n;

   // State and every registered output; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= GRANT_IF;
         last_grant <= GRANT_IF;
         wd_cnt     <= {CNT_W{1'b0}};
         mReq       <= 1'b0;
         mWrite     <= 1'b0;
         mAddr      <= {ADDR_W{1'b0}};
         mWdata     <= {DATA_W{1'b0}};
         mMode      <= 2'b00;
         ifRdata    <= {DATA_W{1'b0}};
         dRdata     <= {DATA_W{1'b0}};
         ifReady    <= 1'b0;
         dReady     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
         wd_cnt     <= wd_cnt_n;
         mReq       <= m_req_n;
         mWrite     <= m_write_n;
         mAddr      <= m_addr_n;
         mWdata     <= m_wdata_n;
         mMode      <= m_mode_n;
         ifRdata    <= if_rdata_n;
         dRdata     <= d_rdata_n;
         ifReady    <= if_ready_n;
         dReady     <= d_ready_n;
         err        <= err_n;
      end
   end

   // Arbitration, handshake and watchdog: next state and next output values.
   always_comb begin
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      wd_cnt_n     = wd_cnt;
      m_req_n      = mReq;
      m_write_n    = mWrite;
      m_addr_n     = mAddr;
      m_wdata_n    = mWdata;
      m_mode_n     = mMode;
      if_rdata_n   = ifRdata;
      d_rdata_n    = dRdata;
      if_ready_n   = 1'b0;
      d_ready_n    = 1'b0;
      err_n        = 1'b0;

      case (state)
         IDLE: begin
            // Data wins when it is alone, or on a tie when IF was served last.
            if (dReq && (!ifReq || (last_grant == GRANT_IF))) begin
               state_n      = BUSY;
               grant_n      = GRANT_D;
               last_grant_n = GRANT_D;
               wd_cnt_n     = {CNT_W{1'b0}};
               m_req_n      = 1'b1;
               m_write_n    = dWrite;
               m_addr_n     = dAddr;
               m_wdata_n    = dWdata;
               m_mode_n     = dMode;
            end else if (ifReq) begin
               state_n      = BUSY;
               grant_n      = GRANT_IF;
               last_grant_n = GRANT_IF;
               wd_cnt_n     = {CNT_W{1'b0}};
               m_req_n      = 1'b1;
               m_write_n    = 1'b0;
               m_addr_n     = ifAddr;
               m_wdata_n    = {DATA_W{1'b0}};
               m_mode_n     = MODE_WORD;
            end else begin
               state_n = IDLE;
            end
         end

         BUSY: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (mAck) begin
               state_n = RESP;
               m_req_n = 1'b0;
               if (grant == GRANT_D) begin
                  d_rdata_n = mRdata;
                  d_ready_n = 1'b1;
               end else begin
                  if_rdata_n = mRdata;
                  if_ready_n = 1'b1;
               end
            end else if (WD_EN && (wd_cnt == WD_LAST)) begin
               state_n = RESP;
               m_req_n = 1'b0;
               err_n   = 1'b1;
               if (grant == GRANT_D) begin
                  d_rdata_n = {DATA_W{1'b0}};
                  d_ready_n = 1'b1;
               end else begin
                  if_rdata_n = {DATA_W{1'b0}};
                  if_ready_n = 1'b1;
               end
            end else if (WD_EN) begin
               wd_cnt_n = wd_cnt + CNT_W'(1);
            end else begin
               wd_cnt_n = wd_cnt;
            end
         end

         RESP: begin
            // Ready is visible this cycle; requests are looked at again in IDLE.
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            m_req_n = 1'b0;
         end
      endcase
   end

   // Freeze the pipeline while any port has a request that has not completed.
   always_comb begin
      stall = (ifReq & ~ifReady) | (dReq & ~dReady);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic [31:0] ifRdata;
   logic        ifReady;
   logic        dReq;
   logic        dWrite;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [1:0]  dMode;
   logic [31:0] dRdata;
   logic        dReady;
   logic        err;
   logic        mReq;
   logic        mWrite;
   logic [31:0] mAddr;
   logic [31:0] mWdata;
   logic [1:0]  mMode;
   logic [31:0] mRdata;
   logic        mAck;
   logic        stall;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifReady(ifReady),
      .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
      .dMode(dMode), .dRdata(dRdata), .dReady(dReady), .err(err),
      .mReq(mReq), .mWrite(mWrite), .mAddr(mAddr), .mWdata(mWdata),
      .mMode(mMode), .mRdata(mRdata), .mAck(mAck), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // Called in the first cycle mReq should be high; acks after `waits` wait
   // cycles, checks the one-cycle ready pulse, drops the request, and returns
   // in the IDLE cycle that follows.
   task automatic serve(input string tag, input logic is_d, input logic [31:0] ea,
                        input logic ew, input logic [1:0] em, input logic [31:0] ewd,
                        input logic [31:0] rd, input int waits);
      for (int w = 0; w <= waits; w++) begin
         chk1 ({tag, "_mreq"},  mReq, 1'b1);
         chk32({tag, "_maddr"}, mAddr, ea);
         chk1 ({tag, "_mwrite"}, mWrite, ew);
         chk32({tag, "_mmode"}, {30'd0, mMode}, {30'd0, em});
         if (ew) chk32({tag, "_mwdata"}, mWdata, ewd);
         chk1 ({tag, "_stall_busy"}, stall, 1'b1);
         if (w == waits) begin
            mAck   = 1'b1;
            mRdata = rd;
         end else begin
            mAck   = 1'b0;
         end
         tick();
      end
      mAck = 1'b0;
      chk1({tag, "_mreq_drop"}, mReq, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
      chk1({tag, "_dready"}, dReady, is_d);
      chk1({tag, "_ifready"}, ifReady, ~is_d);
      chk1({tag, "_stall_done"}, stall, is_d ? ifReq : dReq);
      if (is_d && !ew) chk32({tag, "_drdata"}, dRdata, rd);
      if (!is_d)       chk32({tag, "_ifrdata"}, ifRdata, rd);
      if (is_d) dReq = 1'b0; else ifReq = 1'b0;
      tick();
      chk1({tag, "_dready_1cyc"}, dReady, 1'b0);
      chk1({tag, "_ifready_1cyc"}, ifReady, 1'b0);
   endtask

   initial begin
      rst = 1'b1; ifReq = 1'b0; ifAddr = 32'h0; dReq = 1'b0; dWrite = 1'b0;
      dAddr = 32'h0; dWdata = 32'h0; dMode = 2'b00; mRdata = 32'h0; mAck = 1'b0;
      tick();
      tick();
      // Reset state
      chk1 ("rst_mreq", mReq, 1'b0);
      chk1 ("rst_mwrite", mWrite, 1'b0);
      chk32("rst_maddr", mAddr, 32'h0);
      chk32("rst_mwdata", mWdata, 32'h0);
      chk32("rst_mmode", {30'd0, mMode}, 32'h0);
      chk32("rst_ifrdata", ifRdata, 32'h0);
      chk32("rst_drdata", dRdata, 32'h0);
      chk1 ("rst_ifready", ifReady, 1'b0);
      chk1 ("rst_dready", dReady, 1'b0);
      chk1 ("rst_err", err, 1'b0);
      chk1 ("rst_stall", stall, 1'b0);
      rst = 1'b0;
      tick();

      // First tie after reset: data first, then IF
      ifReq = 1'b1; ifAddr = 32'h0040_0010;
      dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h1001_0004; dMode = 2'b10;
      #1 chk1("tie1_stall_req", stall, 1'b1);
      tick();
      serve("tie1_d", 1'b1, 32'h1001_0004, 1'b0, 2'b10, 32'h0, 32'h1111_2222, 0);
      tick();
      serve("tie1_if", 1'b0, 32'h0040_0010, 1'b0, 2'b10, 32'h0, 32'h3333_4444, 0);
      chk32("drdata_hold", dRdata, 32'h1111_2222);

      // Single zero-wait fetch
      ifReq = 1'b1; ifAddr = 32'h0040_0000;
      #1 chk1("fetch_stall_c0", stall, 1'b1);
      tick();
      serve("fetch", 1'b0, 32'h0040_0000, 1'b0, 2'b10, 32'h0, 32'h2008_000A, 0);

      // Byte store with 3 wait cycles; the ack lands on the watchdog expiry cycle
      dReq = 1'b1; dWrite = 1'b1; dAddr = 32'h1001_0008; dWdata = 32'hDEAD_BEEF; dMode = 2'b00;
      tick();
      serve("store", 1'b1, 32'h1001_0008, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3);

      // Second tie after a data grant: IF first, then data
      ifReq = 1'b1; ifAddr = 32'h0040_0020;
      dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h1001_000C; dMode = 2'b10;
      tick();
      serve("tie2_if", 1'b0, 32'h0040_0020, 1'b0, 2'b10, 32'h0, 32'h5555_6666, 0);
      tick();
      serve("tie2_d", 1'b1, 32'h1001_000C, 1'b0, 2'b10, 32'h0, 32'h7777_8888, 0);

      // Watchdog: no ack for four BUSY cycles
      dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h1001_0010; dMode = 2'b10;
      tick();
      for (int c = 0; c < 4; c++) begin
         chk1("to_mreq_held", mReq, 1'b1);
         tick();
      end
      chk1 ("to_mreq_drop", mReq, 1'b0);
      chk1 ("to_dready", dReady, 1'b1);
      chk1 ("to_err", err, 1'b1);
      chk32("to_drdata", dRdata, 32'h0);
      chk1 ("to_ifready", ifReady, 1'b0);
      dReq = 1'b0;
      tick();
      chk1("to_dready_1cyc", dReady, 1'b0);
      chk1("to_err_1cyc", err, 1'b0);
      chk1("to_mreq_idle", mReq, 1'b0);

      // Spurious ack while idle is ignored
      mAck = 1'b1; mRdata = 32'hFFFF_FFFF;
      tick();
      tick();
      chk1 ("spur_mreq", mReq, 1'b0);
      chk1 ("spur_ifready", ifReady, 1'b0);
      chk1 ("spur_dready", dReady, 1'b0);
      chk32("spur_ifrdata", ifRdata, 32'h5555_6666);
      mAck = 1'b0;

      // Asynchronous reset in the middle of a BUSY store
      dReq = 1'b1; dWrite = 1'b1; dAddr = 32'h1001_0014; dWdata = 32'h1234_5678; dMode = 2'b01;
      tick();
      chk1("ar_mreq_busy", mReq, 1'b1);
      chk1("ar_mwrite_busy", mWrite, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1 ("ar_mreq", mReq, 1'b0);
      chk1 ("ar_mwrite", mWrite, 1'b0);
      chk32("ar_maddr", mAddr, 32'h0);
      chk32("ar_mwdata", mWdata, 32'h0);
      chk32("ar_mmode", {30'd0, mMode}, 32'h0);
      chk32("ar_ifrdata", ifRdata, 32'h0);
      chk32("ar_drdata", dRdata, 32'h0);
      chk1 ("ar_dready", dReady, 1'b0);
      chk1 ("ar_err", err, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      serve("ar_retry", 1'b1, 32'h1001_0014, 1'b1, 2'b01, 32'h1234_5678, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Latches each request, drives the memory with a req/ack handshake, and returns read data with a one-cycle ready pulse.
- Raises a stall to the pipeline while any port is waiting.
- Sits between the pipelined CPU's inst/data buses and the unified memory model.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 64, max cycles mReq may wait for mAck before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifReq  in  1  fetch request; held until ifReady
- ifAddr  in  ADDR_W  fetch address
- ifRdata  out  DATA_W  fetched instruction, valid when ifReady
- ifReady  out  1  one-cycle completion pulse for fetch
- dReq  in  1  data request (memRead|memWrite); held until dReady
- dWrite  in  1  1 = store, 0 = load
- dAddr  in  ADDR_W  data address
- dWdata  in  DATA_W  store data
- dMode  in  2  access mode (byte/half/word), passed through
- dRdata  out  DATA_W  load data, valid when dReady
- dReady  out  1  one-cycle completion pulse for data
- err  out  1  one-cycle pulse with ready when the access timed out
- mReq  out  1  memory request, held until mAck
- mWrite  out  1  memory write enable
- mAddr  out  ADDR_W  memory address
- mWdata  out  DATA_W  memory write data
- mMode  out  2  memory access mode
- mRdata  in  DATA_W  memory read data, valid with mAck
- mAck  in  1  memory completion, may be high in the first mReq cycle
- stall  out  1  pipeline freeze

Behaviour:
- States: IDLE, BUSY, RESP. Registered grant bit (0 = IF, 1 = data) and lastGrant bit.
- All outputs are registered except stall.
- Reset (async): state IDLE; mReq, mWrite, ifReady, dReady, err = 0; mAddr, mWdata, mMode, ifRdata, dRdata = 0; lastGrant = IF; watchdog counter = 0.
- Reset mid-access drops mReq immediately; the access is lost and the requester re-requests after reset.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requests: grant the port that is not lastGrant, so the first tie after reset goes to data.
- On grant: latch addr/wdata/mode/write into the m* registers (IF: mWrite = 0, mMode = word); mReq = 1 next cycle; go to BUSY; lastGrant = granted port.
- BUSY: hold mReq and all m* signals stable until mAck is sampled high.
- On mAck: drop mReq next cycle; latch mRdata into the granted port's rdata register; assert that port's ready for exactly one cycle; go to RESP.
- Store completion also pulses dReady; dRdata is undefined-but-stable and the bench ignores it.
- RESP: ready is high for this cycle; req inputs are ignored; go to IDLE next cycle.
- A request still asserted in IDLE after RESP is treated as a new access.
- Minimum latency: req seen at edge N, mReq high N+1, zero-wait mAck in N+1, ready high N+2.
- Each extra memory wait cycle adds one cycle.
- Watchdog (TIMEOUT > 0): counter clears on entering BUSY and increments each BUSY cycle without mAck.
- When the count reaches TIMEOUT with no ack: drop mReq; pulse the granted ready and err together; rdata = 0; go to RESP.
- An mAck arriving in the same cycle as expiry wins: normal completion, no err.
- stall = (ifReq & ~ifReady) | (dReq & ~dReady), combinational.
- rdata registers hold their value until the next completion on the same port.
- mAck while mReq is low (spurious) is ignored.

Test Plan:
- Single fetch, ifAddr=0x00400000, mAck same cycle as mReq, mRdata=0x2008000A -> mReq high cycle 1; ifReady and ifRdata=0x2008000A in cycle 2; stall high cycles 0-1, low in cycle 2.
- Simultaneous ifReq and load dAddr=0x10010004 right after reset -> data granted first, dReady with mRdata value; then IF served. Next tie -> IF first (alternation verified).
- Store dAddr=0x10010008, dWdata=0xDEADBEEF, dMode=byte, mAck after 3 waits -> mWrite=1, mMode=byte; m* stable for 4 cycles; dReady 1 cycle after ack; no err.
- TIMEOUT=4 with mAck held low -> mReq drops after 4 BUSY cycles; dReady=err=1 for one cycle; dRdata=0; FSM returns to IDLE.
- mAck asserted exactly on the expiry cycle -> normal completion, err=0.
- rst pulsed mid-BUSY, asynchronous to clk -> mReq low immediately; all outputs 0; next request after deassertion completes normally.
